// File: rtl/fetch_queue.sv
// Instruction buffer between IF and ID.
// Holds {pc, instr} pairs, drops all entries on a redirect.
module fetch_queue #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  input  logic [31:0]      enq_pc_i,
  input  logic [31:0]      enq_instr_i,
  output logic             enq_ready_o,
  output logic             deq_valid_o,
  output logic [31:0]      deq_pc_o,
  output logic [31:0]      deq_pc_plus4_o,
  output logic [31:0]      deq_instr_o,
  input  logic             deq_ready_i,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two >= 2");
  end

  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             enq_fire;
  logic             deq_fire;

  assign enq_ready_o = (count != FULL);
  assign deq_valid_o = (count != '0);
  assign count_o     = count;

  // A wrong-path fetch in the flush cycle is dropped,
  // and a head shown during flush is not consumed.
  assign enq_fire = enq_valid_i & enq_ready_o & ~flush_i;
  assign deq_fire = deq_valid_o & deq_ready_i & ~flush_i;

  // Pointer and occupancy state; flush wins over traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count
             + {{PTR_W{1'b0}}, enq_fire}
             - {{PTR_W{1'b0}}, deq_fire};
    end
  end

  // Entry storage, no reset needed.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[wr_ptr]    <= enq_pc_i;
      instr_mem[wr_ptr] <= enq_instr_i;
    end
  end

  assign deq_pc_o       = pc_mem[rd_ptr];
  assign deq_instr_o    = instr_mem[rd_ptr];
  assign deq_pc_plus4_o = deq_pc_o + 32'd4;

  a_no_enq_full : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(enq_fire && count == FULL));

  a_no_deq_empty : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(deq_fire && count == '0));

  a_count_max : assert property (
    @(posedge clk) disable iff (!rst_n)
    count <= FULL);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: table vectors plus
// a scoreboard of expected {pc, instr} entries.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        enq_valid_i;
  logic [31:0] enq_pc_i;
  logic [31:0] enq_instr_i;
  logic        enq_ready_o;
  logic        deq_valid_o;
  logic [31:0] deq_pc_o;
  logic [31:0] deq_pc_plus4_o;
  logic [31:0] deq_instr_o;
  logic        deq_ready_i;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_bad = 0;
  int mcount = 0;
  logic [63:0] sb [$];

  typedef struct {
    logic        flush;
    logic        ev;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        dr;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush_i(flush_i),
    .enq_valid_i(enq_valid_i),
    .enq_pc_i(enq_pc_i),
    .enq_instr_i(enq_instr_i),
    .enq_ready_o(enq_ready_o),
    .deq_valid_o(deq_valid_o),
    .deq_pc_o(deq_pc_o),
    .deq_pc_plus4_o(deq_pc_plus4_o),
    .deq_instr_o(deq_instr_o),
    .deq_ready_i(deq_ready_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge; returns on the next one.
  task automatic step(input logic        fl,
                      input logic        ev,
                      input logic [31:0] pc,
                      input logic [31:0] ins,
                      input logic        dr,
                      input int          exp_cnt);
    logic ef;
    logic df;
    logic [63:0] hd;
    flush_i     = fl;
    enq_valid_i = ev;
    enq_pc_i    = pc;
    enq_instr_i = ins;
    deq_ready_i = dr;
    #1;
    chk("enq_ready", 32'(enq_ready_o), 32'(mcount != DEPTH));
    chk("deq_valid", 32'(deq_valid_o), 32'(mcount != 0));
    if (mcount != 0 && sb.size() != 0) begin
      hd = sb[0];
      chk("deq_pc", deq_pc_o, hd[63:32]);
      chk("deq_instr", deq_instr_o, hd[31:0]);
      chk("deq_pc4", deq_pc_plus4_o, hd[63:32] + 32'd4);
    end
    ef = ev && (mcount != DEPTH) && !fl;
    df = dr && (mcount != 0) && !fl;
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (df) void'(sb.pop_front());
      if (ef) sb.push_back({pc, ins});
      mcount = mcount + int'(ef) - int'(df);
    end
    @(negedge clk);
    chk("count", 32'(count_o), 32'(exp_cnt));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, mcount);
  endtask

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    enq_valid_i = 1'b1;
    enq_pc_i    = 32'hDEAD_0000;
    enq_instr_i = 32'h1;
    deq_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(deq_valid_o), 32'd0);
    chk("rst_ready", 32'(enq_ready_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    enq_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_noenq", 32'(count_o), 32'd0);

    // fill, ignored fifth write, ordered drain
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1'b0, 1'b1, 32'(4 * i),
                      32'hA0 + 32'(i), 1'b0,
                      (i < 4) ? i + 1 : 4});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 1'b0, 32'h0, 32'h0,
                      1'b1, 3 - i});
    foreach (tbl[k])
      step(tbl[k].flush, tbl[k].ev, tbl[k].pc,
           tbl[k].instr, tbl[k].dr, tbl[k].exp_cnt);

    // streaming across the pointer wrap
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 32'h100 + 32'(4 * i),
           32'hB0 + 32'(i), 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0);

    // flush drops held entries and the wrong-path fetch
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h180 + 32'(4 * i),
           32'hC0 + 32'(i), 1'b0, i + 1);
    step(1'b1, 1'b1, 32'h200, 32'hDD, 1'b1, 0);
    step(1'b1, 1'b1, 32'h204, 32'hDE, 1'b0, 0);
    step(1'b0, 1'b1, 32'h300, 32'hE0, 1'b0, 1);
    chk("post_flush_pc", deq_pc_o, 32'h300);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0);

    // full with same-cycle dequeue
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h400 + 32'(4 * i),
           32'hF0 + 32'(i), 1'b0, i + 1);
    step(1'b0, 1'b1, 32'h500, 32'h55, 1'b1, 3);
    chk("full_reopen", 32'(enq_ready_o), 32'd1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2 - i);

    // pc + 4 wraps to zero
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h77, 1'b0, 1);
    chk("pc4_wrap", deq_pc_plus4_o, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0);

    // asynchronous reset mid-run
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h600 + 32'(4 * i),
           32'h60 + 32'(i), 1'b0, i + 1);
    enq_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_valid", 32'(deq_valid_o), 32'd0);
    sb.delete();
    mcount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer directly downstream of the IF stage, feeding the decode stage.
- Captures each fetched {pc, instruction} pair with a valid/ready handshake and decouples fetch from decode stalls.
- Discards all buffered entries on a control-flow redirect (taken branch, JAL, JALR).
- Delivers entries in order, together with PC+4 for the link-register write-back path.

Parameters:
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  redirect from EX (jump or branch taken); empties the queue.
- enq_valid_i  input  1  IF presents a fetched instruction.
- enq_pc_i  input  32  PC of the fetched instruction.
- enq_instr_i  input  32  fetched instruction word.
- enq_ready_o  output  1  queue can accept an entry this cycle.
- deq_valid_o  output  1  head entry available to decode.
- deq_pc_o  output  32  PC of the head entry.
- deq_pc_plus4_o  output  32  head PC + 4.
- deq_instr_o  output  32  head instruction word.
- deq_ready_i  input  1  decode accepts the head entry this cycle.
- count_o  output  PTR_W+1  number of valid entries.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low at any time, including mid-operation, asynchronously clears rd_ptr, wr_ptr and count to 0.
  - Output reset values: enq_ready_o=1, deq_valid_o=0, count_o=0.
  - deq_pc_o, deq_pc_plus4_o and deq_instr_o are don't-care while deq_valid_o=0. The bench checks them only when valid.
- Storage: circular buffer of DEPTH entries. Each entry is {pc[31:0], instr[31:0]}. Storage has no reset.
- Enqueue:
  - Occurs on a rising edge when enq_valid_i & enq_ready_o & !flush_i.
  - Writes the entry at wr_ptr. wr_ptr wraps DEPTH-1 -> 0.
- Dequeue:
  - Occurs on a rising edge when deq_valid_o & deq_ready_i & !flush_i.
  - Advances rd_ptr, with the same wrap rule.
- Readiness and validity:
  - enq_ready_o = (count != DEPTH). It depends only on registered state and has no combinational path from deq_ready_i. When full, a same-cycle dequeue does not open a slot until the next cycle.
  - deq_valid_o = (count != 0). It depends only on registered state.
- Latency: an entry enqueued at edge N is visible on deq_* after edge N (one cycle). There is no same-cycle bypass from enq_* to deq_*.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: both occur and count is unchanged.
- Count update: count_next = count + enq_fire - deq_fire.
  - Never exceeds DEPTH.
  - Never underflows.
- Flush (priority over everything except reset):
  - At the edge where flush_i=1: rd_ptr=wr_ptr=0 and count=0.
  - Enqueue and dequeue in that cycle are suppressed. The IF-side entry presented during the flush cycle belongs to the wrong path and is dropped.
  - In the flush cycle, deq_valid_o still reflects the pre-flush state, because outputs are registered-state functions. Decode must qualify with its own flush, and the queue does not count that entry as consumed.
  - The cycle after flush: deq_valid_o=0 and enq_ready_o=1.
  - Back-to-back flushes keep the queue empty.
- Arithmetic:
  - deq_pc_plus4_o = deq_pc_o + 32'd4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - Pointers are PTR_W bits and wrap naturally.
- Assertions required in RTL:
  - No enqueue when full.
  - No dequeue when empty.
  - count_o <= DEPTH.

Test Plan:
- Reset: hold rst_n=0 with enq_valid_i=1, then release -> deq_valid_o=0, enq_ready_o=1, count_o=0. Assert rst_n=0 asynchronously mid-run with count=3 -> count_o=0 immediately, without waiting for a clock edge.
- Fill/drain in order: enqueue pc 0x00,0x04,0x08,0x0C (instr 0xA0..0xA3) with deq_ready_i=0 -> count_o=4, enq_ready_o=0, and a fifth enqueue attempt is ignored. Then deq_ready_i=1 -> outputs 0x00/0xA0 through 0x0C/0xA3 in order, deq_pc_plus4_o 0x04..0x10, and count_o=0.
- Streaming with wrap: enq_valid_i=1 and deq_ready_i=1 continuously for 10 instructions from pc 0x100 -> after the first cycle, one entry is dequeued per cycle and count_o stays 1. Entries 0x100..0x124 arrive in order across the pointer wrap.
- Flush: with 3 entries held, assert flush_i for one cycle while enq_valid_i=1 (pc 0x200) and deq_ready_i=1 -> next cycle count_o=0, deq_valid_o=0, and 0x200 never appears. Then enqueue pc 0x300 -> it appears on deq_pc_o one cycle later.
- Full with simultaneous dequeue: count=4 and deq_ready_i=1 with enq_valid_i=1 -> that cycle enq_ready_o=0 and no write occurs. The next cycle count_o=3 and enq_ready_o=1.
- PC+4 wrap: enqueue pc 0xFFFFFFFC -> deq_pc_plus4_o=0x00000000.
